dec_4x16_sweep_checker: RTL and testbench

Self-test controller for the 4-to-16 decoder family, including the fault-injected variants. It sits on both sides of the decoder under test:
- Upstream, it drives the 4-bit select inputs X, Y, Z, W through all 16 codes.
- Downstream, it samples the 16-bit D output for each code and compares it against the golden one-hot value.

It records the pass/fail result, a mismatch count, a per-code fail map and the first failing code, so that injected stuck-at faults can be located without a waveform viewer.

---
 rtl/dec_test_pkg.sv | 24 ++
 rtl/misr16.sv | 34 +++
 rtl/dec_4x16_sweep_checker.sv | 167 ++++++++++++++++
 tb/tb_dec_4x16_sweep_checker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_test_pkg.sv
// dec_test_pkg
//   Shared definitions for the 4-to-16 decoder self-test slice:
//     state_t    - sweep controller states (IDLE, APPLY, CHECK, DONE)
//     MISR_POLY  - feedback polynomial of the 16-bit signature register
//     MISR_SEED  - value the signature register starts from
//     expected() - golden one-hot decoder output for a 4-bit code
package dec_test_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h100B;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // A healthy 4-to-16 decoder drives exactly the bit selected by the code.
  function automatic logic [15:0] expected(input logic [3:0] code);
    return 16'h0001 << code;
  endfunction

endpackage

// File: rtl/misr16.sv
// misr16
//   16-bit multiple-input signature register that compacts every decoder
//   output sampled during a sweep into one signature word.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (signature -> seed)
//   seed_load in   reload the seed at the start of a sweep
//   en        in   fold din into the signature this cycle
//   din[15:0] in   decoder output being compacted
//   sig[15:0] out  current signature
module misr16
  import dec_test_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);

  // Shift left, fold the polynomial back in when the MSB falls out, then
  // xor in the parallel input. A seed load wins over a compaction step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= MISR_SEED;
    end else if (seed_load) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ din;
    end
  end

endmodule

// File: rtl/dec_4x16_sweep_checker.sv
// dec_4x16_sweep_checker
//   Self-test controller for a 4-to-16 decoder. On start it walks the select
//   code 0..15 on X..W, holds each code for SETTLE cycles, then compares the
//   decoder output D with the golden one-hot value and records the result.
// Parameters:
//   SETTLE  cycles each code is held before D is sampled (1..15)
// Ports:
//   clk               in   rising-edge clock
//   rst_n             in   asynchronous active-low reset
//   start             in   sweep request, honoured only in IDLE
//   X, Y, Z, W        out  code to the decoder, X is the MSB
//   D[15:0]           in   decoder output under test
//   busy              out  sweep in progress
//   done              out  one-cycle pulse at the end of a sweep
//   pass              out  last completed sweep had no mismatches
//   fail_count[4:0]   out  number of failing codes
//   fail_map[15:0]    out  bit i set when code i failed
//   first_fail[3:0]   out  lowest failing code (valid with first_fail_v)
//   first_fail_v      out  at least one failure recorded
//   sig[15:0]         out  MISR signature of all sampled D values
// Configuration:
//   MISR_EN  when defined, a misr16 compacts D during CHECK; otherwise sig
//            is tied to zero and the port is kept for a stable interface.
module dec_4x16_sweep_checker
  import dec_test_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        X,
  output logic        Y,
  output logic        Z,
  output logic        W,
  input  logic [15:0] D,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  fail_count,
  output logic [15:0] fail_map,
  output logic [3:0]  first_fail,
  output logic        first_fail_v,
  output logic [15:0] sig
);

  // Wait counter value on the last APPLY cycle of a code.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] code;
  logic [3:0] wait_cnt;
  logic       start_accept;
  logic       check_en;
  logic       last_code;
  logic       mismatch;

  assign {X, Y, Z, W} = code;
  assign last_code    = (code == 4'hF);
  assign mismatch     = check_en && (D != expected(code));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Start is only looked at in IDLE, so a request during a sweep or during
  // the DONE cycle is dropped rather than queued.
  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    check_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_next   = APPLY;
        end
      end
      APPLY: begin
        if (wait_cnt == SETTLE_LAST) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        check_en   = 1'b1;
        state_next = last_code ? DONE : APPLY;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sweep datapath and result registers. Results are only cleared by an
  // accepted start, so they stay readable after the sweep has finished.
  // first_fail keeps its old value on start; first_fail_v says whether it
  // belongs to the current sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code         <= 4'd0;
      wait_cnt     <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_count   <= 5'd0;
      fail_map     <= 16'h0000;
      first_fail   <= 4'd0;
      first_fail_v <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_accept) begin
        code         <= 4'd0;
        wait_cnt     <= 4'd0;
        busy         <= 1'b1;
        fail_count   <= 5'd0;
        fail_map     <= 16'h0000;
        first_fail_v <= 1'b0;
      end
      if (state == APPLY) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (state == CHECK) begin
        if (mismatch) begin
          fail_map[code] <= 1'b1;
          fail_count     <= fail_count + 5'd1;
          if (!first_fail_v) begin
            first_fail   <= code;
            first_fail_v <= 1'b1;
          end
        end
        if (last_code) begin
          done <= 1'b1;
          busy <= 1'b0;
        end else begin
          code     <= code + 4'd1;
          wait_cnt <= 4'd0;
        end
      end
      // fail_count already includes the final CHECK by the time DONE runs.
      if (state == DONE) begin
        pass <= (fail_count == 5'd0);
      end
    end
  end

`ifdef MISR_EN
  misr16 u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (start_accept),
    .en        (check_en),
    .din       (D),
    .sig       (sig)
  );
`else
  assign sig = 16'h0000;
`endif

endmodule

// File: tb/tb_dec_4x16_sweep_checker.sv
module tb_dec_4x16_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_b = 1'b0;
  int   fault_mode = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  typedef struct {
    int          mode;
    logic        pass;
    logic [4:0]  cnt;
    logic [15:0] map;
    logic [3:0]  first;
    logic        first_v;
    logic        chk_sig;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];

  // ---------------- DUT A: SETTLE=1, combinational faulty decoder -------
  logic xa, ya, za, wa, busy_a, done_a, pass_a, ffv_a;
  logic [15:0] d_a, map_a, sig_a;
  logic [4:0]  cnt_a;
  logic [3:0]  ff_a, code_a;
  assign code_a = {xa, ya, za, wa};

  always_comb begin
    d_a = 16'h0001 << code_a;
    case (fault_mode)
      1: d_a[7:0] = 8'h00;
      2: d_a[9] = 1'b1;
      3: begin
        if (code_a == 4'd5) d_a[0] = 1'b1;
        else if (code_a == 4'd12) d_a = 16'h0000;
      end
      4: d_a[15] = 1'b0;
      default: ;
    endcase
  end

  dec_4x16_sweep_checker #(.SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .X(xa), .Y(ya), .Z(za), .W(wa), .D(d_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(cnt_a),
    .fail_map(map_a), .first_fail(ff_a), .first_fail_v(ffv_a), .sig(sig_a)
  );

  // ---------------- DUT 2/3: decoder delayed by 3 clocks ----------------
  logic x2, y2, z2, w2, busy2, done2, pass2, ffv2;
  logic x3, y3, z3, w3, busy3, done3, pass3, ffv3;
  logic [15:0] map2, sig2, map3, sig3;
  logic [4:0]  cnt2, cnt3;
  logic [3:0]  ff2, ff3;
  logic [15:0] p2a, p2b, p2c, p3a, p3b, p3c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2a <= 16'h0; p2b <= 16'h0; p2c <= 16'h0;
      p3a <= 16'h0; p3b <= 16'h0; p3c <= 16'h0;
    end else begin
      p2a <= 16'h0001 << {x2, y2, z2, w2}; p2b <= p2a; p2c <= p2b;
      p3a <= 16'h0001 << {x3, y3, z3, w3}; p3b <= p3a; p3c <= p3b;
    end
  end

  dec_4x16_sweep_checker #(.SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .X(x2), .Y(y2), .Z(z2), .W(w2), .D(p2c),
    .busy(busy2), .done(done2), .pass(pass2), .fail_count(cnt2),
    .fail_map(map2), .first_fail(ff2), .first_fail_v(ffv2), .sig(sig2)
  );

  dec_4x16_sweep_checker #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .X(x3), .Y(y3), .Z(z3), .W(w3), .D(p3c),
    .busy(busy3), .done(done3), .pass(pass3), .fail_count(cnt3),
    .fail_map(map3), .first_fail(ff3), .first_fail_v(ffv3), .sig(sig3)
  );

  // ---------------- helpers ---------------------------------------------
  function automatic logic [15:0] misr_ref();
    logic [15:0] s;
    s = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ (16'h0001 << i);
    end
    return s;
  endfunction

  function automatic logic [15:0] exp_sig_done();
`ifdef MISR_EN
    return misr_ref();
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [15:0] exp_sig_reset();
`ifdef MISR_EN
    return 16'hFFFF;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkResetA();
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_done", done_a, 0);
    checkOutput("rst_pass", pass_a, 0);
    checkOutput("rst_fail_count", cnt_a, 0);
    checkOutput("rst_fail_map", map_a, 0);
    checkOutput("rst_first_fail", ff_a, 0);
    checkOutput("rst_first_fail_v", ffv_a, 0);
    checkOutput("rst_code", code_a, 0);
    checkOutput("rst_sig", sig_a, exp_sig_reset());
  endtask

  // Drive one start on DUT A and queue the expected sweep result.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    fault_mode = v.mode;
    start = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("busy_after_start", busy_a, 1);
  endtask

  // Wait for done, pop the scoreboard and compare; optionally poke start
  // in the DONE cycle to show it is dropped.
  task automatic waitSweep(input int exp_lat, input bit poke_done);
    vec_t e;
    int   n;
    bit   seen;
    seen = 1'b0;
    n = 0;
    e = sb.pop_front();
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (done_a) begin
        n = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checkOutput("done_timeout", 0, 1);
      return;
    end
    checkOutput("done_latency", n, exp_lat);
    checkOutput("busy_in_done", busy_a, 0);
    checkOutput("fail_count", cnt_a, e.cnt);
    checkOutput("fail_map", map_a, e.map);
    checkOutput("first_fail_v", ffv_a, e.first_v);
    if (e.first_v) checkOutput("first_fail", ff_a, e.first);
    if (e.chk_sig) checkOutput("sig", sig_a, exp_sig_done());
    if (poke_done) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("done_one_cycle", done_a, 0);
    checkOutput("pass", pass_a, e.pass);
    checkOutput("code_hold_15", code_a, 15);
    if (poke_done) begin
      checkOutput("start_in_done_busy", busy_a, 0);
      @(posedge clk);
      #1 checkOutput("start_in_done_ignored", busy_a, 0);
    end
  endtask

  // ---------------- test sequence ----------------------------------------
  initial begin : main
    int n2, n3, dcount;
    logic [4:0]  c2, c3;
    logic [15:0] m2;
    logic [3:0]  f2;

    vecs[0] = '{0, 1'b1, 5'd0,  16'h0000, 4'd0,  1'b0, 1'b1};
    vecs[1] = '{1, 1'b0, 5'd8,  16'h00FF, 4'd0,  1'b1, 1'b0};
    vecs[2] = '{2, 1'b0, 5'd15, 16'hFDFF, 4'd0,  1'b1, 1'b0};
    vecs[3] = '{3, 1'b0, 5'd2,  16'h1020, 4'd5,  1'b1, 1'b0};
    vecs[4] = '{4, 1'b0, 5'd1,  16'h8000, 4'd15, 1'b1, 1'b0};
    vecs[5] = '{0, 1'b1, 5'd0,  16'h0000, 4'd0,  1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1 checkResetA();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] table-driven sweeps");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      waitSweep(32, i == 4);
    end

    $display("[TB] restart during sweep and reset mid-sweep");
    fault_mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcount = 0;
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkOutput("restart_ignored_code", code_a, 6);
    checkOutput("restart_busy", busy_a, 1);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkResetA();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (done_a) dcount++;
    end
    checkOutput("no_done_after_reset", dcount, 0);
    checkOutput("idle_after_reset", busy_a, 0);
    applyStimulus(vecs[0]);
    waitSweep(32, 1'b0);

    $display("[TB] delayed decoder, SETTLE=2 and SETTLE=3");
    for (int s = 0; s < 2; s++) begin
      n2 = 0; n3 = 0;
      c2 = '0; c3 = '0; m2 = '0; f2 = '0;
      @(negedge clk) start_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b0;
      for (int i = 1; i <= 300; i++) begin
        @(posedge clk);
        #1;
        if (done2 && n2 == 0) begin
          n2 = i; c2 = cnt2; m2 = map2; f2 = ff2;
        end
        if (done3 && n3 == 0) begin
          n3 = i; c3 = cnt3;
        end
        if (n2 != 0 && n3 > 0 && i > n3) break;
      end
      checkOutput("s2_latency", n2, 48);
      checkOutput("s3_latency", n3, 64);
      checkOutput("s3_fail_count", c3, 0);
      checkOutput("s3_pass", pass3, 1);
      checkOutput("s2_pass", pass2, 0);
      checkOutput("s2_fail_count", c2, (s == 0) ? 15 : 16);
      checkOutput("s2_fail_map", m2, (s == 0) ? 16'hFFFE : 16'hFFFF);
      checkOutput("s2_first_fail", f2, (s == 0) ? 1 : 0);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
